// File: rtl/selfcomp_pkg.sv
// Shared definitions for the self-composition leak monitor: FSM encoding and
// the upper bound on the number of monitored copies.
package selfcomp_pkg;

    localparam int MAX_COPIES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2
    } state_t;

endpackage

// File: rtl/selfcomp_arrival_tracker.sv
// Per-copy arrival bookkeeping: remembers whether this copy has delivered its
// result in the current transaction, holds that result, and flags repeat beats.
module selfcomp_arrival_tracker #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              fire,
    input  logic              restart,
    input  logic              abandon,
    input  logic [DATA_W-1:0] data,
    output logic              arrived,
    output logic [DATA_W-1:0] result,
    output logic              overrun
);

    logic              arrived_reg;
    logic [DATA_W-1:0] result_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            arrived_reg <= 1'b0;
            result_reg  <= '0;
        end else if (abandon) begin
            arrived_reg <= 1'b0;
        end else if (restart) begin
            // A new transaction may begin on the very cycle the old one is compared.
            arrived_reg <= fire;
            if (fire) begin
                result_reg <= data;
            end
        end else if (fire && !arrived_reg) begin
            arrived_reg <= 1'b1;
            result_reg  <= data;
        end
    end

    assign arrived = arrived_reg;
    assign result  = result_reg;
    // A repeat beat only counts against the transaction it belongs to.
    assign overrun = fire & arrived_reg & ~restart;

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// Watches the output handshakes of NUM_COPIES identical SE instances and raises
// sticky timing/data/timeout leak flags plus skew and transaction statistics.
module selfcomp_leak_monitor
    import selfcomp_pkg::*;
#(
    parameter int NUM_COPIES = 2,
    parameter int DATA_W     = 128,
    parameter int CNT_W      = 8,
    parameter int SKEW_TOL   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_COPIES-1:0]        io_out_valid,
    input  logic [NUM_COPIES*DATA_W-1:0] io_out_result,
    input  logic                         io_out_ready,
    output logic                         timingLeak,
    output logic                         dataLeak,
    output logic                         timeoutLeak,
    output logic                         leakDone,
    output logic                         allValid,
    output logic [CNT_W-1:0]             lastSkew,
    output logic [CNT_W-1:0]             maxSkew,
    output logic [CNT_W-1:0]             txnCount
);

    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(SKEW_TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t state_reg, state_next;

    logic [NUM_COPIES-1:0] fire;
    logic [NUM_COPIES-1:0] arrived;
    logic [NUM_COPIES-1:0] overrun;
    logic [NUM_COPIES-1:0] differ;
    logic [DATA_W-1:0]     res_q [NUM_COPIES];

    logic [CNT_W-1:0] skew_cnt_reg;
    logic [CNT_W-1:0] last_skew_reg;
    logic [CNT_W-1:0] max_skew_reg;
    logic [CNT_W-1:0] txn_count_reg;
    logic             timing_leak_reg;
    logic             data_leak_reg;
    logic             timeout_leak_reg;

    logic all_fire, any_fire, complete, timed_out;
    logic restart, abandon;

    assign fire      = io_out_valid & {NUM_COPIES{io_out_ready}};
    assign all_fire  = &fire;
    assign any_fire  = |fire;
    assign complete  = &(arrived | fire);
    assign timed_out = (skew_cnt_reg >= TIMEOUT_C);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COPIES; gi++) begin : g_copy
            selfcomp_arrival_tracker #(
                .DATA_W(DATA_W)
            ) u_tracker (
                .clk     (clock),
                .srst    (reset),
                .fire    (fire[gi]),
                .restart (restart),
                .abandon (abandon),
                .data    (io_out_result[gi*DATA_W +: DATA_W]),
                .arrived (arrived[gi]),
                .result  (res_q[gi]),
                .overrun (overrun[gi])
            );
            assign differ[gi] = (res_q[gi] != res_q[0]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        abandon    = 1'b0;
        case (state_reg)
            IDLE, CMP: begin
                restart = 1'b1;
                if (all_fire) begin
                    state_next = CMP;
                end else if (any_fire) begin
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (complete) begin
                    state_next = CMP;
                end else if (timed_out) begin
                    abandon    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            skew_cnt_reg     <= '0;
            last_skew_reg    <= '0;
            max_skew_reg     <= '0;
            txn_count_reg    <= '0;
            timing_leak_reg  <= 1'b0;
            data_leak_reg    <= 1'b0;
            timeout_leak_reg <= 1'b0;
        end else begin
            if (|overrun) begin
                timing_leak_reg <= 1'b1;
            end
            if (restart) begin
                if (all_fire) begin
                    last_skew_reg <= '0;
                end else if (any_fire) begin
                    skew_cnt_reg <= CNT_W'(1);
                end
            end
            if (state_reg == WAIT) begin
                if (complete) begin
                    last_skew_reg <= skew_cnt_reg;
                end else if (abandon) begin
                    timeout_leak_reg <= 1'b1;
                    skew_cnt_reg     <= '0;
                end else begin
                    // Only reached below TIMEOUT, so the counter saturates there.
                    skew_cnt_reg <= skew_cnt_reg + CNT_W'(1);
                end
            end
            if (state_reg == CMP) begin
                if (|differ) begin
                    data_leak_reg <= 1'b1;
                end
                if (last_skew_reg > TOL_C) begin
                    timing_leak_reg <= 1'b1;
                end
                if (last_skew_reg > max_skew_reg) begin
                    max_skew_reg <= last_skew_reg;
                end
                txn_count_reg <= txn_count_reg + CNT_W'(1);
            end
        end
    end

    assign timingLeak  = timing_leak_reg;
    assign dataLeak    = data_leak_reg;
    assign timeoutLeak = timeout_leak_reg;
    assign leakDone    = (state_reg == CMP);
    assign allValid    = &io_out_valid;
    assign lastSkew    = last_skew_reg;
    assign maxSkew     = max_skew_reg;
    assign txnCount    = txn_count_reg;

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Directed bench: a cycle table on a 2-copy monitor plus hand-written overrun,
// skew-tolerance and reset sequences on a 4-copy monitor.
module tb_selfcomp_leak_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 2-copy instance: SKEW_TOL=0, TIMEOUT=4
    logic        rst2;
    logic [1:0]  v2;
    logic        rdy2;
    logic [31:0] res2;
    logic        tl2, dl2, to2, ld2, av2;
    logic [7:0]  ls2, ms2, tc2;

    // 4-copy instance: SKEW_TOL=3, TIMEOUT=4
    logic        rst4;
    logic [3:0]  v4;
    logic        rdy4;
    logic [63:0] res4;
    logic        tl4, dl4, to4, ld4, av4;
    logic [7:0]  ls4, ms4, tc4;

    selfcomp_leak_monitor #(
        .NUM_COPIES(2), .DATA_W(16), .CNT_W(8), .SKEW_TOL(0), .TIMEOUT(4)
    ) u_dut2 (
        .clock(clk), .reset(rst2), .io_out_valid(v2), .io_out_result(res2),
        .io_out_ready(rdy2), .timingLeak(tl2), .dataLeak(dl2), .timeoutLeak(to2),
        .leakDone(ld2), .allValid(av2), .lastSkew(ls2), .maxSkew(ms2), .txnCount(tc2)
    );

    selfcomp_leak_monitor #(
        .NUM_COPIES(4), .DATA_W(16), .CNT_W(8), .SKEW_TOL(3), .TIMEOUT(4)
    ) u_dut4 (
        .clock(clk), .reset(rst4), .io_out_valid(v4), .io_out_result(res4),
        .io_out_ready(rdy4), .timingLeak(tl4), .dataLeak(dl4), .timeoutLeak(to4),
        .leakDone(ld4), .allValid(av4), .lastSkew(ls4), .maxSkew(ms4), .txnCount(tc4)
    );

    typedef struct {
        logic [1:0]  valid;
        logic        ready;
        logic [15:0] r0;
        logic [15:0] r1;
        logic        done;
        logic        tl;
        logic        dl;
        logic        to;
        logic [7:0]  last;
        logic [7:0]  maxs;
        logic [7:0]  txn;
        logic        allv;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] v, input logic r, input logic [63:0] res);
        @(negedge clk);
        v4   = v;
        rdy4 = r;
        res4 = res;
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic done, input logic tl, input logic dl,
                          input logic to, input logic [7:0] last, input logic [7:0] maxs,
                          input logic [7:0] txn);
        $display("dut4 %s valid=%b ready=%b done=%b tl=%b dl=%b to=%b last=%0d max=%0d txn=%0d",
                 tag, v4, rdy4, ld4, tl4, dl4, to4, ls4, ms4, tc4);
        check({tag, " leakDone"},    32'(ld4), 32'(done));
        check({tag, " timingLeak"},  32'(tl4), 32'(tl));
        check({tag, " dataLeak"},    32'(dl4), 32'(dl));
        check({tag, " timeoutLeak"}, 32'(to4), 32'(to));
        check({tag, " lastSkew"},    32'(ls4), 32'(last));
        check({tag, " maxSkew"},     32'(ms4), 32'(maxs));
        check({tag, " txnCount"},    32'(tc4), 32'(txn));
    endtask

    initial begin
        //           valid  rdy   r0      r1       done tl  dl  to  last  max   txn   allv
        vecs[0]  = '{2'b11, 1'b1, 16'h5, 16'h5,  1'b1,1'b0,1'b0,1'b0, 8'd0, 8'd0, 8'd0, 1'b1};
        vecs[1]  = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b0,1'b0,1'b0, 8'd0, 8'd0, 8'd1, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 16'hA, 16'hB,  1'b1,1'b0,1'b0,1'b0, 8'd0, 8'd0, 8'd1, 1'b1};
        vecs[3]  = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd2, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 16'h5, 16'h5,  1'b1,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd2, 1'b1};
        vecs[5]  = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd3, 1'b0};
        vecs[6]  = '{2'b01, 1'b1, 16'h7, 16'h0,  1'b0,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd3, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd3, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b0,1'b1,1'b0, 8'd0, 8'd0, 8'd3, 1'b0};
        vecs[9]  = '{2'b10, 1'b1, 16'h0, 16'h7,  1'b1,1'b0,1'b1,1'b0, 8'd3, 8'd0, 8'd3, 1'b0};
        vecs[10] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b0, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[11] = '{2'b01, 1'b1, 16'h1, 16'h0,  1'b0,1'b1,1'b1,1'b0, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[12] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b0, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[13] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b0, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[14] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b0, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[15] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b1, 8'd3, 8'd3, 8'd4, 1'b0};
        vecs[16] = '{2'b11, 1'b1, 16'h3, 16'h3,  1'b1,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd4, 1'b1};
        vecs[17] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd5, 1'b0};
        vecs[18] = '{2'b11, 1'b0, 16'h9, 16'h8,  1'b0,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd5, 1'b1};
        vecs[19] = '{2'b11, 1'b0, 16'h9, 16'h8,  1'b0,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd5, 1'b1};
        vecs[20] = '{2'b11, 1'b1, 16'h2, 16'h2,  1'b1,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd5, 1'b1};
        vecs[21] = '{2'b11, 1'b1, 16'h2, 16'h2,  1'b1,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd6, 1'b1};
        vecs[22] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd7, 1'b0};
        vecs[23] = '{2'b11, 1'b1, 16'h4, 16'h4,  1'b1,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd7, 1'b1};
        vecs[24] = '{2'b01, 1'b1, 16'h4, 16'h0,  1'b0,1'b1,1'b1,1'b1, 8'd0, 8'd3, 8'd8, 1'b0};
        vecs[25] = '{2'b10, 1'b1, 16'h0, 16'h4,  1'b1,1'b1,1'b1,1'b1, 8'd1, 8'd3, 8'd8, 1'b0};
        vecs[26] = '{2'b00, 1'b1, 16'h0, 16'h0,  1'b0,1'b1,1'b1,1'b1, 8'd1, 8'd3, 8'd9, 1'b0};

        // Reset both instances; valids held high on dut4 to show allValid is stateless.
        rst2 = 1'b1; v2 = 2'b00; rdy2 = 1'b1; res2 = '0;
        rst4 = 1'b1; v4 = 4'b1111; rdy4 = 1'b1; res4 = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("reset state: dut2 done=%b txn=%0d, dut4 allValid=%b", ld2, tc2, av4);
        check("reset2 flags", 32'({tl2, dl2, to2, ld2}), 32'(0));
        check("reset2 counters", 32'({ls2, ms2, tc2}), 32'(0));
        check("reset4 allValid", 32'(av4), 32'(1));
        check4("reset4", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

        @(negedge clk);
        rst2 = 1'b0;
        rst4 = 1'b0;
        v4   = 4'b0000;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            v2   = vecs[i].valid;
            rdy2 = vecs[i].ready;
            res2 = {vecs[i].r1, vecs[i].r0};
            @(posedge clk);
            #1;
            $display("vec %0d valid=%b ready=%b done=%b tl=%b dl=%b to=%b last=%0d max=%0d txn=%0d allv=%b",
                     i, v2, rdy2, ld2, tl2, dl2, to2, ls2, ms2, tc2, av2);
            check($sformatf("vec%0d leakDone", i),    32'(ld2), 32'(vecs[i].done));
            check($sformatf("vec%0d timingLeak", i),  32'(tl2), 32'(vecs[i].tl));
            check($sformatf("vec%0d dataLeak", i),    32'(dl2), 32'(vecs[i].dl));
            check($sformatf("vec%0d timeoutLeak", i), 32'(to2), 32'(vecs[i].to));
            check($sformatf("vec%0d lastSkew", i),    32'(ls2), 32'(vecs[i].last));
            check($sformatf("vec%0d maxSkew", i),     32'(ms2), 32'(vecs[i].maxs));
            check($sformatf("vec%0d txnCount", i),    32'(tc2), 32'(vecs[i].txn));
            check($sformatf("vec%0d allValid", i),    32'(av2), 32'(vecs[i].allv));
        end

        // Overrun: copy0 at t, copies 1,2 at t+1, copies 1(again),3 at t+2.
        // The repeat beat carries a different value that must not be captured.
        drive4(4'b0001, 1'b1, {16'h11, 16'h11, 16'h11, 16'h11});
        check4("ovr t0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive4(4'b0110, 1'b1, {16'h11, 16'h11, 16'h11, 16'h11});
        check("ovr t1 allValid", 32'(av4), 32'(0));
        check4("ovr t1", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive4(4'b1010, 1'b1, {16'h11, 16'h11, 16'hFF, 16'h11});
        check4("ovr t2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0);
        drive4(4'b0000, 1'b1, '0);
        check4("ovr t3", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2, 8'd1);

        // Reset clears everything after a completed transaction.
        @(negedge clk);
        rst4 = 1'b1;
        drive4(4'b0000, 1'b1, '0);
        check4("rst after ovr", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst4 = 1'b0;

        // Skew of 3 is within SKEW_TOL=3.
        drive4(4'b0011, 1'b1, {16'h22, 16'h22, 16'h22, 16'h22});
        drive4(4'b0000, 1'b1, '0);
        drive4(4'b0000, 1'b1, '0);
        check4("tol t2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive4(4'b1100, 1'b1, {16'h22, 16'h22, 16'h22, 16'h22});
        check4("tol t3", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0);
        drive4(4'b0000, 1'b1, '0);
        check4("tol t4", 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 8'd1);

        // Valids high but ready low: no arrivals.
        drive4(4'b1111, 1'b0, {16'h1, 16'h2, 16'h3, 16'h4});
        check("noready allValid", 32'(av4), 32'(1));
        drive4(4'b0000, 1'b1, '0);
        check4("noready", 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd3, 8'd1);

        // Reset in WAIT discards the partial transaction.
        drive4(4'b0001, 1'b1, {16'h5, 16'h5, 16'h5, 16'h5});
        @(negedge clk);
        rst4 = 1'b1;
        drive4(4'b0000, 1'b1, '0);
        check4("rst in wait", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst4 = 1'b0;
        drive4(4'b1110, 1'b1, {16'h6, 16'h6, 16'h6, 16'h6});
        check4("post rst partial", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive4(4'b0000, 1'b1, '0);
        drive4(4'b0001, 1'b1, {16'h6, 16'h6, 16'h6, 16'h6});
        check4("post rst done", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0);
        drive4(4'b0000, 1'b1, '0);
        check4("post rst cmp", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
